// File: rtl/score_keeper.sv
// Game-statistics accumulator: BCD score, lines and level digits for the status area.
// A small sequential engine adds the base score (level+1) times, then updates lines and level.
module score_keeper #(
  parameter int NUMBER_LEN      = 6,
  parameter int MAX_LEVEL       = 20,
  parameter int LINES_PER_LEVEL = 10
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       new_game_i,
  input  logic                       clear_stb_i,
  input  logic [2:0]                 clear_cnt_i,
  output logic [NUMBER_LEN-1:0][3:0] score_o,
  output logic [NUMBER_LEN-1:0][3:0] lines_o,
  output logic [NUMBER_LEN-1:0][3:0] level_o,
  output logic                       busy_o,
  output logic                       level_up_o
);

  typedef logic [NUMBER_LEN-1:0][3:0] bcd_t;
  typedef enum logic [1:0] {IDLE, ADD_SCORE, ADD_LINES, LEVEL} state_t;

  // Handshake: clear_stb_i has no ready; busy_o=1 means "not ready" and any
  // strobe seen while busy (or with a count outside 1..4) is dropped, never queued.

  function automatic bcd_t bcd_add(input bcd_t a, input bcd_t b);
    bcd_t       r;
    logic [4:0] s;
    logic       c;
    r = '0;
    c = 1'b0;
    for (int i = 0; i < NUMBER_LEN; i++) begin
      s = {1'b0, a[i]} + {1'b0, b[i]} + {4'b0, c};
      if (s > 5'd9) begin
        r[i] = 4'(s - 5'd10);
        c    = 1'b1;
      end else begin
        r[i] = s[3:0];
        c    = 1'b0;
      end
    end
    // Overflow out of the top digit pins the counter at all nines.
    if (c) r = {NUMBER_LEN{4'd9}};
    return r;
  endfunction

  function automatic bcd_t digit_bcd(input logic [3:0] d);
    bcd_t r;
    r    = '0;
    r[0] = d;
    return r;
  endfunction

  function automatic bcd_t base_for(input logic [2:0] cnt);
    bcd_t r;
    r = '0;
    case (cnt)
      3'd1:    r[1] = 4'd4;
      3'd2:    r[2] = 4'd1;
      3'd3:    r[2] = 4'd3;
      3'd4:    begin r[3] = 4'd1; r[2] = 4'd2; end
      default: r = '0;
    endcase
    return r;
  endfunction

  state_t     state_q, state_d;
  bcd_t       score_q, score_d;
  bcd_t       lines_q, lines_d;
  bcd_t       level_q, level_d;
  bcd_t       base_q, base_d;
  logic [6:0] level_bin_q, level_bin_d;
  logic [6:0] iter_q, iter_d;
  logic [2:0] cnt_q, cnt_d;
  logic       busy_q, busy_d;
  logic       level_up_q, level_up_d;

  always_comb begin
    state_d     = state_q;
    score_d     = score_q;
    lines_d     = lines_q;
    level_d     = level_q;
    base_d      = base_q;
    level_bin_d = level_bin_q;
    iter_d      = iter_q;
    cnt_d       = cnt_q;
    busy_d      = busy_q;
    level_up_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (clear_stb_i && clear_cnt_i >= 3'd1 && clear_cnt_i <= 3'd4) begin
          cnt_d   = clear_cnt_i;
          base_d  = base_for(clear_cnt_i);
          iter_d  = level_bin_q + 7'd1;
          busy_d  = 1'b1;
          state_d = ADD_SCORE;
        end
      end
      ADD_SCORE: begin
        score_d = bcd_add(score_q, base_q);
        iter_d  = iter_q - 7'd1;
        if (iter_q == 7'd1) state_d = ADD_LINES;
      end
      ADD_LINES: begin
        lines_d = bcd_add(lines_q, digit_bcd({1'b0, cnt_q}));
        // The pending level-up is registered here so the pulse lines up with LEVEL.
        level_up_d = (({1'b0, lines_q[0]} + {2'b0, cnt_q}) >= 5'(LINES_PER_LEVEL)) &&
                     (level_bin_q < 7'(MAX_LEVEL));
        state_d = LEVEL;
      end
      LEVEL: begin
        if (level_up_q) begin
          level_d     = bcd_add(level_q, digit_bcd(4'd1));
          level_bin_d = level_bin_q + 7'd1;
        end
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || new_game_i) begin
      state_q     <= IDLE;
      score_q     <= '0;
      lines_q     <= '0;
      level_q     <= '0;
      base_q      <= '0;
      level_bin_q <= '0;
      iter_q      <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      level_up_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      score_q     <= score_d;
      lines_q     <= lines_d;
      level_q     <= level_d;
      base_q      <= base_d;
      level_bin_q <= level_bin_d;
      iter_q      <= iter_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      level_up_q  <= level_up_d;
    end
  end

  assign score_o    = score_q;
  assign lines_o    = lines_q;
  assign level_o    = level_q;
  assign busy_o     = busy_q;
  assign level_up_o = level_up_q;

endmodule

// File: tb/tb_score_keeper.sv
// Bench for score_keeper: directed vector table, hand-written abort/reset sequences,
// and random events checked against an integer-arithmetic model of the scoring rules.
module tb_score_keeper;

  localparam int NL = 6;

  logic                clk = 1'b0;
  logic                rst;
  logic                new_game;
  logic                clear_stb;
  logic [2:0]          clear_cnt;
  logic [NL-1:0][3:0]  score;
  logic [NL-1:0][3:0]  lines;
  logic [NL-1:0][3:0]  level;
  logic                busy;
  logic                level_up;

  int n_tests = 0;
  int n_fail  = 0;

  int m_score = 0;
  int m_lines = 0;
  int m_level = 0;

  logic [23:0] exp_q[$];

  typedef struct {
    logic [2:0]  cnt;
    int          intrude;
    logic [23:0] score;
    logic [23:0] lines;
    logic [23:0] level;
    int          busy_n;
    int          lu_n;
  } vec_t;

  vec_t vecs[10];

  score_keeper #(.NUMBER_LEN(NL), .MAX_LEVEL(20), .LINES_PER_LEVEL(10)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .new_game_i  (new_game),
    .clear_stb_i (clear_stb),
    .clear_cnt_i (clear_cnt),
    .score_o     (score),
    .lines_o     (lines),
    .level_o     (level),
    .busy_o      (busy),
    .level_up_o  (level_up)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [23:0] to_bcd(input int v);
    logic [23:0] r;
    int          x;
    r = '0;
    x = v;
    for (int i = 0; i < 6; i++) begin
      r[i*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Reference model: applies one event to integer counters.
  task automatic model_event(input int cnt, output int exp_busy, output int exp_lu);
    int  base;
    bit  wrap;
    exp_busy = 0;
    exp_lu   = 0;
    if (cnt >= 1 && cnt <= 4) begin
      base     = (cnt == 1) ? 40 : (cnt == 2) ? 100 : (cnt == 3) ? 300 : 1200;
      exp_busy = m_level + 3;
      m_score  = m_score + base * (m_level + 1);
      if (m_score > 999999) m_score = 999999;
      wrap     = ((m_lines % 10) + cnt) >= 10;
      m_lines  = m_lines + cnt;
      if (m_lines > 999999) m_lines = 999999;
      if (wrap && m_level < 20) begin
        m_level++;
        exp_lu = 1;
      end
    end
  endtask

  task automatic model_clear();
    m_score = 0;
    m_lines = 0;
    m_level = 0;
  endtask

  // Driver: one strobe, then watch busy with a cycle budget. Optionally re-strobe
  // during busy cycle number 'intrude' (that strobe must be dropped).
  task automatic do_event(input logic [2:0] cnt, input int intrude, output int nbusy,
                          output int lu_n, output int lu_pos, output int timed_out);
    nbusy     = 0;
    lu_n      = 0;
    lu_pos    = 0;
    timed_out = 1;
    @(negedge clk);
    clear_stb = 1'b1;
    clear_cnt = cnt;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      clear_stb = 1'b0;
      if (!busy) begin
        timed_out = 0;
        break;
      end
      nbusy++;
      if (level_up) begin
        lu_n++;
        lu_pos = nbusy;
      end
      if (nbusy == intrude) begin
        clear_stb = 1'b1;
        clear_cnt = 3'($urandom_range(1, 4));
      end
    end
    clear_stb = 1'b0;
  endtask

  task automatic run_and_check(input string tag, input logic [2:0] cnt, input int intrude);
    int nb, lun, lup, to, eb, elu;
    do_event(cnt, intrude, nb, lun, lup, to);
    model_event(int'(cnt), eb, elu);
    exp_q.push_back(to_bcd(m_score));
    exp_q.push_back(to_bcd(m_lines));
    exp_q.push_back(to_bcd(m_level));
    check({tag, "_timeout"}, to, 0);
    check({tag, "_busy_cycles"}, nb, eb);
    check({tag, "_level_up_count"}, lun, elu);
    if (elu != 0) check({tag, "_level_up_in_last_cycle"}, lup, eb);
    check({tag, "_score"}, score, exp_q.pop_front());
    check({tag, "_lines"}, lines, exp_q.pop_front());
    check({tag, "_level"}, level, exp_q.pop_front());
  endtask

  task automatic pulse_new_game();
    @(negedge clk);
    new_game = 1'b1;
    @(negedge clk);
    new_game = 1'b0;
    model_clear();
  endtask

  task automatic check_all_clear(input string tag);
    check({tag, "_score"}, score, 0);
    check({tag, "_lines"}, lines, 0);
    check({tag, "_level"}, level, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_level_up"}, level_up, 0);
  endtask

  initial begin
    int nb, lun, lup, to;

    rst       = 1'b1;
    new_game  = 1'b0;
    clear_stb = 1'b0;
    clear_cnt = 3'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_clear("reset");
    rst = 1'b0;

    // Directed vectors from reset; each row builds on the previous one.
    vecs[0] = '{3'd1, 0, 24'h000040, 24'h000001, 24'h000000, 3, 0};
    vecs[1] = '{3'd4, 2, 24'h001240, 24'h000005, 24'h000000, 3, 0};
    vecs[2] = '{3'd4, 0, 24'h002440, 24'h000009, 24'h000000, 3, 0};
    vecs[3] = '{3'd2, 0, 24'h002540, 24'h000011, 24'h000001, 3, 1};
    vecs[4] = '{3'd3, 1, 24'h003140, 24'h000014, 24'h000001, 4, 0};
    vecs[5] = '{3'd0, 0, 24'h003140, 24'h000014, 24'h000001, 0, 0};
    vecs[6] = '{3'd7, 0, 24'h003140, 24'h000014, 24'h000001, 0, 0};
    vecs[7] = '{3'd4, 0, 24'h005540, 24'h000018, 24'h000001, 4, 0};
    vecs[8] = '{3'd2, 0, 24'h005740, 24'h000020, 24'h000002, 4, 1};
    vecs[9] = '{3'd4, 3, 24'h009340, 24'h000024, 24'h000002, 5, 0};

    for (int i = 0; i < 10; i++) begin
      do_event(vecs[i].cnt, vecs[i].intrude, nb, lun, lup, to);
      check($sformatf("vec%0d_timeout", i), to, 0);
      check($sformatf("vec%0d_busy_cycles", i), nb, vecs[i].busy_n);
      check($sformatf("vec%0d_level_up_count", i), lun, vecs[i].lu_n);
      if (vecs[i].lu_n != 0) check($sformatf("vec%0d_level_up_pos", i), lup, vecs[i].busy_n);
      check($sformatf("vec%0d_score", i), score, vecs[i].score);
      check($sformatf("vec%0d_lines", i), lines, vecs[i].lines);
      check($sformatf("vec%0d_level", i), level, vecs[i].level);
    end

    // Abort: climb to level 5, start a 3-row event, new game in its 2nd ADD_SCORE cycle.
    pulse_new_game();
    check_all_clear("new_game");
    for (int i = 0; i < 13; i++) run_and_check("climb", 3'd4, 0);
    check("climb_level5", level, 24'h000005);
    @(negedge clk);
    clear_stb = 1'b1;
    clear_cnt = 3'd3;
    @(negedge clk);
    check("abort_busy_c1", busy, 1);
    clear_cnt = 3'd4;
    @(negedge clk);
    clear_stb = 1'b0;
    check("abort_busy_c2", busy, 1);
    check("abort_partial_score", score, to_bcd(m_score + 300));
    new_game = 1'b1;
    @(negedge clk);
    new_game = 1'b0;
    model_clear();
    check_all_clear("abort");
    run_and_check("ignore_cnt0", 3'd0, 0);
    run_and_check("ignore_cnt7", 3'd7, 0);

    // Reset in the first busy cycle.
    run_and_check("pre_rst", 3'd1, 0);
    @(negedge clk);
    clear_stb = 1'b1;
    clear_cnt = 3'd2;
    @(negedge clk);
    clear_stb = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    check_all_clear("rst_midop");

    // Random events, including invalid counts and strobes dropped during busy.
    for (int i = 0; i < 40; i++)
      run_and_check("rand", 3'($urandom_range(0, 7)), $urandom_range(0, 4));

    // Saturation and level cap: pump 4-row events until score is pinned at level 20.
    pulse_new_game();
    for (int i = 0; i < 200 && !(m_score == 999999 && m_level == 20); i++)
      run_and_check("pump", 3'd4, 0);
    check("sat_score", score, 24'h999999);
    check("sat_level", level, 24'h000020);
    for (int i = 0; i < 4; i++) run_and_check("sat_hold", 3'($urandom_range(1, 4)), 0);
    check("sat_score_held", score, 24'h999999);
    check("sat_level_capped", level, 24'h000020);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/score_keeper.md
Name: score_keeper

Overview:
- Game-statistics writer that produces the decimal score, lines and level digits shown in the status area.
- Takes "rows cleared" events from the game logic and accumulates score, lines and level as per-digit BCD arrays; the text renderer adds the ASCII '0' offset to each digit.
- Score is built by a small sequential BCD-add engine: the base value is added (level+1) times, one addition per cycle, then the lines and level counts are updated.
- Sits between the game FSM and the status/text drawing path.

Parameters:
- NUMBER_LEN, 6, decimal digits per counter (score, lines, level).
- MAX_LEVEL, 20, level saturation value in decimal (0..99).
- LINES_PER_LEVEL, 10, lines per level-up; fixed at 10, units-digit wrap is the trigger.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  synchronous active-high reset
- new_game_i  in  1  single-cycle pulse; clear all counters
- clear_stb_i  in  1  single-cycle strobe; clear_cnt_i valid
- clear_cnt_i  in  3  rows cleared by this event (1..4)
- score_o  out  NUMBER_LEN x 4  BCD score digits; index 0 = least significant
- lines_o  out  NUMBER_LEN x 4  BCD lines digits; index 0 = LSD
- level_o  out  NUMBER_LEN x 4  BCD level digits; index 0 = LSD
- busy_o  out  1  high while an event is being processed
- level_up_o  out  1  one-cycle pulse when the level increments

Behaviour:
- Interface: one clock (clk_i). Reset rst_i is synchronous and active-high.
- Reset and new_game_i behave the same, and have the highest priority, including mid-operation:
  - all digits go to 0, busy_o=0, level_up_o=0, FSM returns to IDLE, iteration counter=0;
  - they take effect on the next clock edge and abort any event in progress.
- Base score by clear_cnt_i: 1→40, 2→100, 3→300, 4→1200 (held internally as 6-digit BCD constant).
- Strobe acceptance:
  - accepted only in IDLE with clear_cnt_i in 1..4;
  - clear_cnt_i of 0 or 5..7 is ignored;
  - a strobe while busy_o=1 is dropped; no queueing.
- On acceptance, latch clear_cnt_i and the base value, and load the iteration counter = binary level (internal binary copy of level) + 1.
- FSM states:
  - IDLE: wait for a valid strobe; go to ADD_SCORE.
  - ADD_SCORE: each cycle, score ← BCD_add(score, base) and counter−1; when counter reaches 1 (last add), go to ADD_LINES.
  - ADD_LINES: lines ← BCD_add(lines, clear_cnt); record whether the lines units digit wrapped (sum ≥ 10); go to LEVEL.
  - LEVEL: if a wrap was recorded and level < MAX_LEVEL, increment level (BCD and binary copy) and pulse level_up_o for this cycle; go to IDLE.
- Latency: strobe sampled at edge T → busy_o=1 from T+1. ADD_SCORE lasts L+1 cycles (L = level before the event), ADD_LINES 1 cycle, LEVEL 1 cycle. Final values and busy_o=0 are visible after T+L+4.
- Score multiplier uses the level before this event; a level-up caused by this event applies to the next event.
- BCD add:
  - per digit: sum = a + b + carry; if sum > 9, subtract 10 and carry 1;
  - ripple over all digits in one cycle.
- Saturation: if the carry out of the top digit is 1, the counter is forced to all 9s (999999) and stays there until reset or new game.
- Outputs are direct register outputs and change only on clock edges. Partial score values are visible while busy_o=1; the renderer tolerates this.

Test Plan:
- Reset, then strobe cnt=1 at level 0 → busy_o high 3 cycles, then score=000040, lines=000001, level=000000, no level_up_o pulse.
- Preload via events to level 2 (lines=20), strobe cnt=4 → ADD_SCORE lasts exactly 3 cycles, score increases by 3600, lines=24, level stays 2.
- lines=000009 at level 0, strobe cnt=2 → score +100, lines=000011, level=000001, level_up_o pulses once in the LEVEL cycle.
- Drive score to 999990, strobe cnt=1 → score=999999; further events keep it at 999999; lines still increment.
- Strobe cnt=3 at level 5, assert new_game_i in the 2nd ADD_SCORE cycle → next cycle all digits 0, busy_o=0; a second strobe during busy and strobes with cnt=0 or cnt=7 leave all outputs unchanged.
- At level MAX_LEVEL=20, cross a multiple of 10 in lines → level stays 000020, no level_up_o pulse.
